// File: rtl/seq_alu.sv
// Registered, valid/ready-handshaked integer ALU with an iterative radix-2 unsigned multiply.
// One operation in flight; single-cycle ops load their result at the accept edge.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MBUSY, DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
    OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
    OP_OR = 4'd8, OP_AND = 4'd9, OP_MUL = 4'd10
  } op_e;

  state_e             state, state_nx;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [SHW:0]       cnt;
  logic               accept, is_mul, mul_last;
  logic [WIDTH-1:0]   res;
  logic               res_flag, res_err;
  logic [WIDTH:0]     mac;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (sel == OP_MUL);
  assign mul_last  = (cnt == (SHW+1)'(WIDTH));
  // Multiplier lives in the low half of acc; each step adds mcand to the high half and shifts right.
  assign mac       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};

  always_comb begin
    res      = '0;
    res_flag = 1'b0;
    res_err  = 1'b0;
    case (sel)
      OP_ADD:  {res_flag, res} = {1'b0, a} + {1'b0, b};
      OP_SUB:  begin res = a - b; res_flag = (a < b); end
      OP_SLL:  res = a << b[SHW-1:0];
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  res = a ^ b;
      OP_SRL:  res = a >> b[SHW-1:0];
      OP_SRA:  res = $signed(a) >>> b[SHW-1:0];
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      OP_MUL:  res = '0;
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = is_mul ? MBUSY : DONE;
      MBUSY:   if (mul_last) state_nx = DONE;
      DONE: begin
        if (out_ready) begin
          if (in_valid) state_nx = is_mul ? MBUSY : DONE;
          else          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out   <= '0;
      flag  <= 1'b0;
      err   <= 1'b0;
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else if (accept) begin
      if (is_mul) begin
        acc   <= {{WIDTH{1'b0}}, b};
        mcand <= a;
        cnt   <= '0;
      end else begin
        out  <= res;
        flag <= res_flag;
        err  <= res_err;
      end
    end else if (state == MBUSY) begin
      if (mul_last) begin
        out  <= acc[WIDTH-1:0];
        flag <= |acc[2*WIDTH-1:WIDTH];
        err  <= 1'b0;
      end else begin
        acc <= {mac, acc[WIDTH-1:1]};
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: stimulus pushes hand-computed results into a queue,
// a negedge monitor pops and compares on every retiring handshake.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, flag, err;
  logic [W-1:0] a, b, out;
  logic [3:0]   sel;

  typedef struct {
    logic [W-1:0] o;
    logic         f;
    logic         e;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flag(flag), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a result retires on the next posedge whenever out_valid && out_ready here.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_result", 64'(out), 64'hDEAD_0000_0000);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_out", 64'(out), 64'(e.o));
        check("sb_flag", 64'(flag), 64'(e.f));
        check("sb_err", 64'(err), 64'(e.e));
      end
    end
  end

  // Offers one op, waits (bounded) for in_ready, returns 1 time unit after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] eo, input logic ef, input logic ee, input bit push);
    int n;
    exp_t e;
    in_valid = 1'b1; sel = op; a = va; b = vb;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("accept_timeout", 64'(in_ready), 64'd1);
    if (push) begin
      e.o = eo; e.f = ef; e.e = ee;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((out_valid === 1'b1 || q.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("drain_timeout", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    sel = 4'd0; a = 32'd1; b = 32'd1;

    // Reset with in_valid held high
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out", 64'(out), 64'd0);
      check("rst_flag", 64'(flag), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 64'(out_valid), 64'd0);

    // ADD carry, then back-to-back SUB borrow
    issue(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b1);
    check("add_latency", 64'(out_valid), 64'd1);
    issue(4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);
    check("sub_b2b_valid", 64'(out_valid), 64'd1);
    check("sub_b2b_out", 64'(out), 64'hFFFF_FFFE);

    // Shifts and compares; upper bits of b ignored for shift amounts
    issue(4'd7, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1'b0, 1'b1);
    issue(4'd6, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1'b0, 1'b1);
    issue(4'd2, 32'h0000_0001, 32'h21, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
    issue(4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
    issue(4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1);
    issue(4'd8, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1'b0, 1'b0, 1'b1);
    issue(4'd1, 32'd9, 32'd4, 32'd5, 1'b0, 1'b0, 1'b1);
    drain();

    // MUL latency: busy through the edge WIDTH after accept, result at WIDTH+1
    issue(4'd10, 32'h1_0000, 32'h1_0000, 32'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < W + 1; i++) begin
      check("mul_busy_in_ready", 64'(in_ready), 64'd0);
      check("mul_busy_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    check("mul_latency", 64'(out_valid), 64'd1);
    drain();
    issue(4'd10, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 1'b1);
    drain();
    issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
    drain();

    // Backpressure on an XOR result, then retire-and-accept AND
    out_ready = 1'b0;
    issue(4'd5, 32'hF0F0_1234, 32'h0FF0_4321, 32'hFF00_5115, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out", 64'(out), 64'hFF00_5115);
      check("bp_flag", 64'(flag), 64'd0);
      check("bp_err", 64'(err), 64'd0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    issue(4'd9, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0, 1'b1);
    check("bp_and_valid", 64'(out_valid), 64'd1);
    check("bp_and_out", 64'(out), 64'h0F00_0F00);
    drain();

    // Illegal opcode
    issue(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b1, 1'b1);
    drain();

    // Reset mid-MUL abandons the op
    issue(4'd10, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out", 64'(out), 64'd0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2 * W; i++) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b0) seen = 1'b1;
      end
      check("abort_no_result", 64'(seen), 64'd0);
    end

    // Normal operation resumes after the abort
    issue(4'd0, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 1'b1);
    drain();
    check("queue_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
